clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Multi-channel programmable clock/tick divider, the parametrised successor of the single-channel pulse divider.
- Generates NUM_CH independent divided outputs from clk_i. Each channel has a selectable pulse or ~50% square-wave mode.
- Ratio/mode updates go through a valid/ready handshake and take effect glitch-free at the next period boundary.
- A global sync input phase-aligns all channels. Used for peripheral baud/tick generation (UART, SPI, timers).

Parameters:
- NUM_CH, 4, number of independent divider channels (>=1).
- RATIO_WIDTH, 16, width of the divide ratio per channel.
- RESET_RATIO, 2, active ratio of every channel after reset (1..2^RATIO_WIDTH-1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- en_i  in  NUM_CH  per-channel enable
- sync_i  in  1  restart all enabled channels at phase 0
- cfg_valid_i  in  NUM_CH  per-channel config request
- cfg_ready_o  out  NUM_CH  per-channel config accept
- cfg_ratio_i  in  NUM_CH x RATIO_WIDTH  requested ratio
- cfg_mode_i  in  NUM_CH x 1  requested mode (0 = pulse, 1 = square)
- cfg_applied_o  out  NUM_CH  1-cycle pulse when the pending config becomes active
- tick_o  out  NUM_CH  1-cycle pulse per period (both modes)
- clk_o  out  NUM_CH  divided output (pulse copy or square wave, per mode)

Behaviour:
- Reset values:
  - counter = 0, active ratio = RESET_RATIO, active mode = pulse.
  - pending = 0, cfg_ready_o = all 1.
  - tick_o, clk_o, cfg_applied_o = all 0.
- All outputs are registered. Ratio value 0 is treated as 1.
- Per channel, let R = active ratio, C = counter. Priority at each clk_i edge: ~en_i > sync_i > count.
- en_i low:
  - C <= 0; tick_o and clk_o <= 0.
  - A pending config is applied at this edge (cfg_applied_o pulses next cycle).
- sync_i high (channel enabled):
  - C <= 0, tick_o <= 0.
  - clk_o <= 1 in square mode, 0 in pulse mode.
  - A pending config is also applied at this edge.
- Count (enabled, no sync):
  - If C == R-1: C <= 0 and tick_o <= 1 (period boundary); otherwise C <= C+1 and tick_o <= 0.
  - Pulse mode: clk_o equals tick_o.
  - Square mode: clk_o <= 1 when next C < ceil(R/2), else 0. High for ceil(R/2) cycles, low for floor(R/2).
  - R=1 in square mode: clk_o held constant 1, tick_o high every cycle.
- Latency: with en_i rising and held, the first tick_o is seen R cycles after the first enabled edge, then one tick every R cycles. R=1 gives tick_o continuously high.
- Handshake:
  - cfg_ready_o = ~pending.
  - On cfg_valid_i & cfg_ready_o: latch ratio/mode into the shadow register and set pending (ready low from the next cycle).
  - The pending config becomes active at the next boundary edge (C == R-1), sync edge, or any edge with en_i low. At that edge pending clears.
  - cfg_applied_o pulses the following cycle; cfg_ready_o is high again the same cycle.
  - A new request is never accepted in the same cycle one is applied, so there are no collisions.
  - cfg_valid_i while ready is low is ignored; the requester holds valid.
- Counter arithmetic is RATIO_WIDTH bits unsigned. R-1 is computed on the active ratio only, so no wrap occurs given the 0->1 mapping.
- Channels are fully independent except for the shared sync_i.
- Asynchronous reset mid-operation returns all state to reset values immediately; shadow contents are discarded.

Decomposition:
- Shared package clk_div_pkg:
  - typedef enum logic {DIV_MODE_PULSE, DIV_MODE_SQUARE} div_mode_e.
  - Default RATIO_WIDTH constant.
- Sub-module clk_div_ch, one channel: counter, shadow/pending logic, output regs.
- Top clk_div_multi: generate loop over NUM_CH plus sync_i fan-out.

Test Plan:
- Reset, then en_i[0]=1, ratio=RESET_RATIO=2, pulse mode -> tick_o[0] high every 2nd cycle; first tick 2 cycles after enable; clk_o[0] == tick_o[0].
- Config ch1 ratio=5, mode=square while running at R=2 -> ready drops next cycle; new config applied at next boundary; cfg_applied_o[1] single pulse; clk_o[1] then repeats 3 high / 2 low with no runt period.
- cfg_ratio=0 and cfg_ratio=1 in pulse mode -> tick_o continuously high. Same ratios in square mode -> clk_o constant 1.
- Two channels at R=4 and R=6, offset enables, assert sync_i for 1 cycle -> both counters restart; ticks coincide every 12 cycles thereafter.
- en_i low while a config is pending -> applied at next edge; outputs 0. Re-enable -> first tick after the new R cycles.
- rst_ni asserted mid-period with a config pending -> all outputs 0 immediately. After release: cfg_ready_o all 1, ratio back to RESET_RATIO.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the multi-channel clock/tick divider.
package clk_div_pkg;

  typedef enum logic {DIV_MODE_PULSE, DIV_MODE_SQUARE} div_mode_e;

  localparam int unsigned DIV_RATIO_WIDTH = 16;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, shadow config with pending flag,
// and registered tick/clock/applied outputs.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned RATIO_WIDTH = DIV_RATIO_WIDTH,
  parameter int unsigned RESET_RATIO = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   sync_i,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [RATIO_WIDTH-1:0] cfg_ratio_i,
  input  logic                   cfg_mode_i,
  output logic                   cfg_applied_o,
  output logic                   tick_o,
  output logic                   clk_o
);

  localparam logic [RATIO_WIDTH-1:0] RESET_R =
    (RESET_RATIO == 0) ? RATIO_WIDTH'(1) : RATIO_WIDTH'(RESET_RATIO);

  logic [RATIO_WIDTH-1:0] cnt_q, cnt_d;
  logic [RATIO_WIDTH-1:0] ratio_q, ratio_d;
  logic [RATIO_WIDTH-1:0] shadow_ratio_q, shadow_ratio_d;
  div_mode_e              mode_q, mode_d;
  div_mode_e              shadow_mode_q, shadow_mode_d;
  logic                   pend_q, pend_d;
  logic                   tick_q, tick_d;
  logic                   clk_q, clk_d;
  logic                   applied_q, applied_d;

  logic [RATIO_WIDTH-1:0] last;
  logic [RATIO_WIDTH-1:0] half;
  logic                   boundary;
  logic                   accept;
  logic                   apply;

  // Ratios are stored already mapped 0 -> 1, so ratio_q - 1 never wraps.
  always_comb begin
    last     = ratio_q - RATIO_WIDTH'(1);
    boundary = (cnt_q == last);
    accept   = cfg_valid_i & ~pend_q;
    apply    = pend_q & (~en_i | sync_i | boundary);

    cnt_d          = cnt_q;
    ratio_d        = ratio_q;
    mode_d         = mode_q;
    shadow_ratio_d = shadow_ratio_q;
    shadow_mode_d  = shadow_mode_q;
    pend_d         = pend_q;
    tick_d         = 1'b0;
    clk_d          = 1'b0;
    applied_d      = 1'b0;

    if (accept) begin
      shadow_ratio_d = (cfg_ratio_i == '0) ? RATIO_WIDTH'(1) : cfg_ratio_i;
      shadow_mode_d  = div_mode_e'(cfg_mode_i);
      pend_d         = 1'b1;
    end

    if (apply) begin
      ratio_d   = shadow_ratio_q;
      mode_d    = shadow_mode_q;
      pend_d    = 1'b0;
      applied_d = 1'b1;
    end

    half = (ratio_d >> 1) + {{(RATIO_WIDTH-1){1'b0}}, ratio_d[0]};

    // A new config only lands at a boundary/sync/disable edge, where the
    // counter restarts at 0, so the first period after a change is never a runt.
    if (!en_i) begin
      cnt_d = '0;
    end else if (sync_i) begin
      cnt_d = '0;
      clk_d = (mode_d == DIV_MODE_SQUARE);
    end else if (boundary) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      clk_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + RATIO_WIDTH'(1);
      clk_d = (mode_d == DIV_MODE_SQUARE) && (cnt_d < half);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q          <= '0;
      ratio_q        <= RESET_R;
      mode_q         <= DIV_MODE_PULSE;
      shadow_ratio_q <= RESET_R;
      shadow_mode_q  <= DIV_MODE_PULSE;
      pend_q         <= 1'b0;
      tick_q         <= 1'b0;
      clk_q          <= 1'b0;
      applied_q      <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      ratio_q        <= ratio_d;
      mode_q         <= mode_d;
      shadow_ratio_q <= shadow_ratio_d;
      shadow_mode_q  <= shadow_mode_d;
      pend_q         <= pend_d;
      tick_q         <= tick_d;
      clk_q          <= clk_d;
      applied_q      <= applied_d;
    end
  end

  assign cfg_ready_o   = ~pend_q;
  assign cfg_applied_o = applied_q;
  assign tick_o        = tick_q;
  assign clk_o         = clk_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/tick divider: NUM_CH independent
// channels sharing one sync input for phase alignment.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned RATIO_WIDTH = DIV_RATIO_WIDTH,
  parameter int unsigned RESET_RATIO = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_CH-1:0]                   en_i,
  input  logic                                sync_i,
  input  logic [NUM_CH-1:0]                   cfg_valid_i,
  output logic [NUM_CH-1:0]                   cfg_ready_o,
  input  logic [NUM_CH-1:0][RATIO_WIDTH-1:0]  cfg_ratio_i,
  input  logic [NUM_CH-1:0]                   cfg_mode_i,
  output logic [NUM_CH-1:0]                   cfg_applied_o,
  output logic [NUM_CH-1:0]                   tick_o,
  output logic [NUM_CH-1:0]                   clk_o
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_ch #(
      .RATIO_WIDTH (RATIO_WIDTH),
      .RESET_RATIO (RESET_RATIO)
    ) u_ch (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .en_i          (en_i[g]),
      .sync_i        (sync_i),
      .cfg_valid_i   (cfg_valid_i[g]),
      .cfg_ready_o   (cfg_ready_o[g]),
      .cfg_ratio_i   (cfg_ratio_i[g]),
      .cfg_mode_i    (cfg_mode_i[g]),
      .cfg_applied_o (cfg_applied_o[g]),
      .tick_o        (tick_o[g]),
      .clk_o         (clk_o[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi; inputs are driven and
// outputs sampled on the falling clock edge.
module tb_clk_div_multi;

  localparam int NUM_CH = 4;
  localparam int RW     = 16;

  logic                         clk_i;
  logic                         rst_ni;
  logic [NUM_CH-1:0]            en_i;
  logic                         sync_i;
  logic [NUM_CH-1:0]            cfg_valid_i;
  logic [NUM_CH-1:0]            cfg_ready_o;
  logic [NUM_CH-1:0][RW-1:0]    cfg_ratio_i;
  logic [NUM_CH-1:0]            cfg_mode_i;
  logic [NUM_CH-1:0]            cfg_applied_o;
  logic [NUM_CH-1:0]            tick_o;
  logic [NUM_CH-1:0]            clk_o;

  int n_cmp;
  int n_err;

  clk_div_multi #(
    .NUM_CH      (NUM_CH),
    .RATIO_WIDTH (RW),
    .RESET_RATIO (2)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .en_i          (en_i),
    .sync_i        (sync_i),
    .cfg_valid_i   (cfg_valid_i),
    .cfg_ready_o   (cfg_ready_o),
    .cfg_ratio_i   (cfg_ratio_i),
    .cfg_mode_i    (cfg_mode_i),
    .cfg_applied_o (cfg_applied_o),
    .tick_o        (tick_o),
    .clk_o         (clk_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_ni      = 1'b1;
    en_i        = '0;
    sync_i      = 1'b0;
    cfg_valid_i = '0;
    cfg_ratio_i = '0;
    cfg_mode_i  = '0;
    #2 rst_ni = 1'b0;
    step();
    n_cmp++;
    if (cfg_ready_o !== 4'hF) begin
      n_err++;
      $display("[TB] FAIL reset_ready: got %h expected %h", cfg_ready_o, 4'hF);
    end
    n_cmp++;
    if ({tick_o, clk_o, cfg_applied_o} !== 12'h000) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", {tick_o, clk_o, cfg_applied_o}, 12'h000);
    end
    rst_ni = 1'b1;
    step();
    n_cmp++;
    if ({tick_o, clk_o, cfg_applied_o, cfg_ready_o} !== 16'h000F) begin
      n_err++;
      $display("[TB] FAIL reset_idle: got %h expected %h", {tick_o, clk_o, cfg_applied_o, cfg_ready_o}, 16'h000F);
    end
  endtask

  // Channel 0 at the reset ratio 2 in pulse mode.
  task automatic test_pulse_basic();
    en_i = 4'b0001;
    for (int i = 1; i <= 6; i++) begin
      logic exp_t;
      step();
      exp_t = (i % 2 == 0);
      n_cmp++;
      if (tick_o[0] !== exp_t || clk_o[0] !== exp_t) begin
        n_err++;
        $display("[TB] FAIL pulse_r2 cyc%0d: got tick=%b clk=%b expected %b", i, tick_o[0], clk_o[0], exp_t);
      end
      n_cmp++;
      if (tick_o[3:1] !== 3'b000) begin
        n_err++;
        $display("[TB] FAIL pulse_idle_ch cyc%0d: got %b expected 000", i, tick_o[3:1]);
      end
    end
  endtask

  // Channel 1 reconfigured to ratio 5 square while running at ratio 2.
  task automatic test_cfg_square();
    en_i = 4'b0000;
    step();
    en_i           = 4'b0010;
    cfg_valid_i[1] = 1'b1;
    cfg_ratio_i[1] = 16'd5;
    cfg_mode_i[1]  = 1'b1;
    step();
    cfg_valid_i[1] = 1'b0;
    n_cmp++;
    if (cfg_ready_o[1] !== 1'b0 || cfg_applied_o[1] !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL cfg_accept: got ready=%b applied=%b expected 0 0", cfg_ready_o[1], cfg_applied_o[1]);
    end
    for (int j = 0; j < 12; j++) begin
      logic exp_c, exp_t, exp_a;
      step();
      exp_c = ((j % 5) < 3);
      exp_t = ((j % 5) == 0);
      exp_a = (j == 0);
      n_cmp++;
      if (clk_o[1] !== exp_c || tick_o[1] !== exp_t || cfg_applied_o[1] !== exp_a || cfg_ready_o[1] !== 1'b1) begin
        n_err++;
        $display("[TB] FAIL square_r5 cyc%0d: got clk=%b tick=%b app=%b rdy=%b expected %b %b %b 1",
                 j, clk_o[1], tick_o[1], cfg_applied_o[1], cfg_ready_o[1], exp_c, exp_t, exp_a);
      end
    end
  endtask

  // Ratios 0 and 1 in both modes on channel 2, loaded while disabled.
  task automatic test_ratio_one();
    logic [RW-1:0] ratios [4];
    logic          modes  [4];
    ratios = '{16'd0, 16'd1, 16'd0, 16'd1};
    modes  = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int c = 0; c < 4; c++) begin
      en_i           = 4'b0000;
      cfg_valid_i[2] = 1'b1;
      cfg_ratio_i[2] = ratios[c];
      cfg_mode_i[2]  = modes[c];
      step();
      cfg_valid_i[2] = 1'b0;
      n_cmp++;
      if (cfg_ready_o[2] !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL r1_ready case%0d: got %b expected 0", c, cfg_ready_o[2]);
      end
      step();
      n_cmp++;
      if (cfg_applied_o[2] !== 1'b1 || tick_o[2] !== 1'b0 || clk_o[2] !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL r1_applied case%0d: got app=%b tick=%b clk=%b expected 1 0 0",
                 c, cfg_applied_o[2], tick_o[2], clk_o[2]);
      end
      en_i = 4'b0100;
      for (int k = 1; k <= 5; k++) begin
        step();
        n_cmp++;
        if (tick_o[2] !== 1'b1 || clk_o[2] !== 1'b1) begin
          n_err++;
          $display("[TB] FAIL r1_const case%0d cyc%0d: got tick=%b clk=%b expected 1 1", c, k, tick_o[2], clk_o[2]);
        end
      end
    end
  endtask

  // Channels 0 and 3 at ratios 4 and 6, enabled at different times, then synced.
  task automatic test_sync();
    en_i           = 4'b0000;
    cfg_valid_i    = 4'b1001;
    cfg_ratio_i[0] = 16'd4;
    cfg_ratio_i[3] = 16'd6;
    cfg_mode_i     = 4'b0000;
    step();
    cfg_valid_i = 4'b0000;
    step();
    n_cmp++;
    if (cfg_applied_o !== 4'b1001) begin
      n_err++;
      $display("[TB] FAIL sync_cfg_applied: got %b expected 1001", cfg_applied_o);
    end
    en_i = 4'b0001;
    step();
    step();
    en_i = 4'b1001;
    step();
    step();
    step();
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    n_cmp++;
    if (tick_o !== 4'b0000) begin
      n_err++;
      $display("[TB] FAIL sync_edge: got %b expected 0000", tick_o);
    end
    for (int k = 1; k <= 24; k++) begin
      logic [1:0] exp_t;
      step();
      exp_t = {(k % 6 == 0), (k % 4 == 0)};
      n_cmp++;
      if ({tick_o[3], tick_o[0]} !== exp_t) begin
        n_err++;
        $display("[TB] FAIL sync_align cyc%0d: got %b expected %b", k, {tick_o[3], tick_o[0]}, exp_t);
      end
    end
  endtask

  // Disable channel 0 while a ratio-3 config is pending.
  task automatic test_disable_pending();
    en_i           = 4'b0001;
    cfg_valid_i[0] = 1'b1;
    cfg_ratio_i[0] = 16'd3;
    cfg_mode_i[0]  = 1'b0;
    step();
    cfg_valid_i[0] = 1'b0;
    n_cmp++;
    if (cfg_ready_o[0] !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL dis_pending: got %b expected 0", cfg_ready_o[0]);
    end
    en_i = 4'b0000;
    step();
    n_cmp++;
    if (cfg_applied_o[0] !== 1'b1 || cfg_ready_o[0] !== 1'b1 || tick_o[0] !== 1'b0 || clk_o[0] !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL dis_apply: got app=%b rdy=%b tick=%b clk=%b expected 1 1 0 0",
               cfg_applied_o[0], cfg_ready_o[0], tick_o[0], clk_o[0]);
    end
    en_i = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      logic exp_t;
      step();
      exp_t = (k % 3 == 0);
      n_cmp++;
      if (tick_o[0] !== exp_t || cfg_applied_o[0] !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL dis_reenable cyc%0d: got tick=%b app=%b expected %b 0", k, tick_o[0], cfg_applied_o[0], exp_t);
      end
    end
  endtask

  // Asynchronous reset mid-period on channel 1 with a config pending.
  task automatic test_reset_mid();
    en_i           = 4'b0010;
    cfg_valid_i[1] = 1'b1;
    cfg_ratio_i[1] = 16'd7;
    cfg_mode_i[1]  = 1'b1;
    step();
    cfg_valid_i[1] = 1'b0;
    n_cmp++;
    if (cfg_ready_o[1] !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL rstmid_pending: got %b expected 0", cfg_ready_o[1]);
    end
    #2 rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({tick_o, clk_o, cfg_applied_o, cfg_ready_o} !== 16'h000F) begin
      n_err++;
      $display("[TB] FAIL rstmid_async: got %h expected %h", {tick_o, clk_o, cfg_applied_o, cfg_ready_o}, 16'h000F);
    end
    step();
    step();
    rst_ni = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      logic exp_t;
      step();
      exp_t = (k % 2 == 0);
      n_cmp++;
      if (tick_o[1] !== exp_t || clk_o[1] !== exp_t || cfg_ready_o !== 4'hF) begin
        n_err++;
        $display("[TB] FAIL rstmid_after cyc%0d: got tick=%b clk=%b rdy=%h expected %b %b F",
                 k, tick_o[1], clk_o[1], cfg_ready_o, exp_t, exp_t);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_pulse_basic();
    test_cfg_square();
    test_ratio_one();
    test_sync();
    test_disable_pending();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
